// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: sequences a UART program download into instruction memory and holds the core in reset meanwhile
module boot_loader_ctrl #(
  parameter int IMEM_ADDR_W    = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flash,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   core_hold,
  output logic                   loading,
  output logic                   load_error,
  output logic [15:0]            words_loaded
);
  typedef enum logic [2:0] {RUN, LEN0, LEN1, DATA, CSUM, DONE, ERROR} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << IMEM_ADDR_W;
  state_t state, state_nx;
  logic [2:0] fsync;
  logic [7:0] len_lo;
  logic [15:0] len;
  logic [1:0] bcnt;
  logic [23:0] wbuf;
  logic [7:0] csum;
  logic [TW-1:0] timer;
  logic flash_edge, busy, take, timeout, last_word;
  logic [16:0] len_in;
  assign flash_edge = fsync[1] & ~fsync[2];
  assign busy = state inside {LEN0, LEN1, DATA, CSUM};
  // a restart wins over a byte arriving in the same cycle
  assign take = busy & rx_valid & ~flash_edge;
  assign timeout = busy & ~rx_valid & (timer == TW'(TIMEOUT_CYCLES - 1));
  assign last_word = bcnt == 2'd3 && words_loaded == len - 16'd1;
  assign len_in = {1'b0, rx_data, len_lo};
  assign core_hold = state != RUN;
  assign loading = busy;
  assign load_error = state == ERROR;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      fsync <= '0;
    end else begin
      state <= state_nx;
      fsync <= {fsync[1:0], flash};
    end
  end
  always_comb begin
    state_nx = state;
    if (flash_edge) state_nx = LEN0;
    else if (timeout) state_nx = ERROR;
    else if (state == DONE) state_nx = RUN;
    else if (take)
      case (state)
        LEN0: state_nx = LEN1;
        LEN1: state_nx = len_in > MAX_WORDS ? ERROR : len_in == '0 ? CSUM : DATA;
        DATA: state_nx = last_word ? CSUM : DATA;
        CSUM: state_nx = (csum ^ rx_data) == 8'h00 ? DONE : ERROR;
        default: state_nx = state;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      words_loaded <= '0;
      len_lo <= '0;
      len <= '0;
      bcnt <= '0;
      wbuf <= '0;
      csum <= '0;
      timer <= '0;
    end else begin
      imem_we <= 1'b0;
      if (flash_edge) begin
        imem_addr <= '0;
        words_loaded <= '0;
        bcnt <= '0;
        csum <= '0;
        timer <= '0;
      end else if (busy) begin
        timer <= take ? '0 : timer + TW'(1);
        if (take) begin
          csum <= csum ^ rx_data;
          if (state == LEN0) len_lo <= rx_data;
          if (state == LEN1) len <= {rx_data, len_lo};
          if (state == DATA) begin
            bcnt <= bcnt + 2'd1;
            wbuf <= {rx_data, wbuf[23:8]};
            if (bcnt == 2'd3) begin
              imem_we <= 1'b1;
              imem_wdata <= {rx_data, wbuf};
              imem_addr <= words_loaded[IMEM_ADDR_W-1:0];
              words_loaded <= words_loaded + 16'(words_loaded != 16'hFFFF);
            end
          end
        end
      end
    end
  end
endmodule
